io_bus_responder: RTL and testbench

- Memory-mapped peripheral that sits on the responder side of the CPU I/O bus (io_addr, io_dout, io_we, io_rd, io_din).
- Decodes I/O accesses into a small register set:
  - LED register
  - synchronized switches
  - sticky button-edge capture
  - free-running cycle counter
  - TX FIFO drained to an external consumer via valid/ready
- Read data returns combinationally in the same cycle. Side effects (writes, clear-on-read, FIFO push) commit on the rising clock edge.

---
 rtl/io_map_pkg.sv | 41 ++++
 rtl/io_bus_if.sv | 11 +
 rtl/io_sync_fifo.sv | 66 ++++++
 rtl/io_bus_responder.sv | 126 ++++++++++++
 tb/tb_io_bus_responder.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_map_pkg.sv
// Address map, TXS field positions and address decode shared by the I/O bus responder.
package io_map_pkg;

    localparam logic [15:0] IO_LED  = 16'hFF00;
    localparam logic [15:0] IO_SW   = 16'hFF04;
    localparam logic [15:0] IO_BTN  = 16'hFF08;
    localparam logic [15:0] IO_TXD  = 16'hFF0C;
    localparam logic [15:0] IO_TXS  = 16'hFF10;
    localparam logic [15:0] IO_CNT  = 16'hFF14;
    localparam logic [15:0] IO_CNTC = 16'hFF18;

    localparam int TXS_FULL_BIT  = 0;
    localparam int TXS_EMPTY_BIT = 1;
    localparam int TXS_OVF_BIT   = 2;
    localparam int TXS_CNT_LSB   = 4;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_TXD,
        SEL_TXS,
        SEL_CNT,
        SEL_CNTC
    } io_sel_e;

    function automatic io_sel_e decode_addr(input logic [15:0] addr);
        case (addr)
            IO_LED:  return SEL_LED;
            IO_SW:   return SEL_SW;
            IO_BTN:  return SEL_BTN;
            IO_TXD:  return SEL_TXD;
            IO_TXS:  return SEL_TXS;
            IO_CNT:  return SEL_CNT;
            IO_CNTC: return SEL_CNTC;
            default: return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/io_bus_if.sv
// CPU I/O bus: the CPU is the master, peripherals attach through the slave modport.
interface io_bus_if;
    logic [15:0] io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din;

    modport master (output io_addr, io_dout, io_we, io_rd, input io_din);
    modport slave  (input io_addr, io_dout, io_we, io_rd, output io_din);
endinterface

// File: rtl/io_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module io_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Gating with empty gives a defined head value without resetting the storage.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; pointers and count alone define which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped LED/switch/button/counter/TX-FIFO peripheral on the CPU I/O bus.
module io_bus_responder
    import io_map_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SW_W       = 16,
    parameter int BTN_W      = 5,
    parameter int LED_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    io_bus_if.slave          bus,
    input  logic [SW_W-1:0]  sw,
    input  logic [BTN_W-1:0] btn,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    io_sel_e          sel;
    logic             wr_en, rd_en;
    logic             fifo_push, fifo_full, fifo_empty, pop_fire;
    logic [CW-1:0]    fifo_count;
    logic [31:0]      rdata;
    logic [BTN_W-1:0] btn_rise;
    logic             unused_dout;

    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic [BTN_W-1:0] btn_meta_q, btn_meta_d, btn_sync_q, btn_sync_d;
    logic [BTN_W-1:0] btn_prev_q, btn_prev_d, btn_flags_q, btn_flags_d;
    logic [31:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    assign sel         = decode_addr(bus.io_addr);
    assign wr_en       = bus.io_we;
    assign rd_en       = bus.io_rd;
    assign fifo_push   = wr_en && (sel == SEL_TXD);
    assign tx_valid    = !fifo_empty;
    assign pop_fire    = tx_valid && tx_ready;
    assign btn_rise    = btn_sync_q & ~btn_prev_q;
    assign led         = led_q;
    assign unused_dout = ^bus.io_dout;

    io_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fifo_push),
        .wdata (bus.io_dout[7:0]),
        .pop   (tx_ready),
        .rdata (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // NOTE: every output gets a default first so no path leaves a value held, which would infer a latch.
    always_comb begin
        led_d = led_q;
        if (wr_en && sel == SEL_LED) led_d = bus.io_dout[LED_W-1:0];

        sw_meta_d  = sw;
        sw_sync_d  = sw_meta_q;
        btn_meta_d = btn;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;

        // Clear-on-read first, then new edges, so a coincident edge survives the read.
        btn_flags_d = (rd_en && sel == SEL_BTN) ? '0 : btn_flags_q;
        btn_flags_d = btn_flags_d | btn_rise;

        ovf_d = (rd_en && sel == SEL_TXS) ? 1'b0 : ovf_q;
        if (fifo_push && fifo_full && !pop_fire) ovf_d = 1'b1;

        cnt_d = cnt_q + 32'd1;
        if (wr_en && sel == SEL_CNTC && bus.io_dout[0]) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q       <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            btn_meta_q  <= '0;
            btn_sync_q  <= '0;
            btn_prev_q  <= '0;
            btn_flags_q <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            led_q       <= led_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
            btn_meta_q  <= btn_meta_d;
            btn_sync_q  <= btn_sync_d;
            btn_prev_q  <= btn_prev_d;
            btn_flags_q <= btn_flags_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    // Reads see pre-edge register values, so a same-cycle write is not visible yet.
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_LED: rdata[LED_W-1:0] = led_q;
            SEL_SW:  rdata[SW_W-1:0]  = sw_sync_q;
            SEL_BTN: rdata[BTN_W-1:0] = btn_flags_q;
            SEL_TXS: begin
                rdata[TXS_FULL_BIT]       = fifo_full;
                rdata[TXS_EMPTY_BIT]      = fifo_empty;
                rdata[TXS_OVF_BIT]        = ovf_q;
                rdata[TXS_CNT_LSB +: CW]  = fifo_count;
            end
            SEL_CNT: rdata = cnt_q;
            default: rdata = '0;
        endcase
    end

    assign bus.io_din = rd_en ? rdata : 32'd0;

endmodule

// File: tb/tb_io_bus_responder.sv
// Scoreboard bench: stimulus queues expected read data and TX bytes; a negedge monitor checks them.
module tb_io_bus_responder;
    import io_map_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] sw;
    logic [4:0]  btn;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    io_bus_if bus();

    io_bus_responder #(.FIFO_DEPTH(4), .SW_W(16), .BTN_W(5), .LED_W(16)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .sw       (sw),
        .btn      (btn),
        .led      (led),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rd_q[$];
    string       rd_name_q[$];
    logic [7:0]  exp_tx_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every read strobe and every accepted TX byte consumes one expected entry.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.io_rd) begin
                if (exp_rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rd_unexpected: got 0x%08h, expected no read", bus.io_din);
                end else begin
                    automatic logic [31:0] e  = exp_rd_q.pop_front();
                    automatic string       nm = rd_name_q.pop_front();
                    check(nm, bus.io_din, e);
                end
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tx_unexpected: got 0x%02h, expected no byte", tx_data);
                end else begin
                    automatic logic [7:0] e = exp_tx_q.pop_front();
                    check("tx_byte", 32'(tx_data), 32'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] a, input logic [31:0] e, input string nm);
        exp_rd_q.push_back(e);
        rd_name_q.push_back(nm);
        bus.io_addr = a;
        bus.io_rd   = 1'b1;
        tick();
        bus.io_rd   = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        bus.io_addr = a;
        bus.io_dout = d;
        bus.io_we   = 1'b1;
        tick();
        bus.io_we   = 1'b0;
    endtask

    task automatic wait_tx_empty(input string nm);
        for (int i = 0; i < 20 && tx_valid; i++) tick();
        check(nm, 32'(tx_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] fill1 [5];
        logic [7:0] fill2 [4];
        fill1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        fill2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};

        bus.io_addr = '0;
        bus.io_dout = '0;
        bus.io_we   = 1'b0;
        bus.io_rd   = 1'b0;
        sw          = '0;
        btn         = '0;
        tx_ready    = 1'b0;
        rstn        = 1'b0;
        repeat (3) tick();
        check("rst_led", 32'(led), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        rstn = 1'b1;
        tick();

        bus_read(IO_TXS, 32'h0000_0002, "rst_txs");
        bus_read(IO_BTN, 32'h0, "rst_btn");

        // LED register and unmapped address
        bus_write(IO_LED, 32'h0000_A5A5);
        check("led_out", 32'(led), 32'h0000_A5A5);
        bus_read(IO_LED, 32'h0000_A5A5, "led_rd");
        bus_read(16'hFF40, 32'h0, "unmapped_rd");

        // Switch synchronizer latency
        sw = 16'h1234;
        tick();
        bus_read(IO_SW, 32'h0, "sw_plus1");
        bus_read(IO_SW, 32'h0000_1234, "sw_plus2");

        // Button edge capture, clear-on-read, and set-beats-clear
        btn = 5'b00100;
        repeat (3) tick();
        bus_read(IO_BTN, 32'h4, "btn_edge");
        bus_read(IO_BTN, 32'h0, "btn_clr");
        btn = 5'b00000;
        repeat (4) tick();
        btn = 5'b00100;
        repeat (2) tick();
        bus_read(IO_BTN, 32'h0, "btn_coincident_rd");
        bus_read(IO_BTN, 32'h4, "btn_set_wins");
        bus_read(IO_BTN, 32'h0, "btn_clr2");

        // Cycle counter: clear, increment spacing, wrap
        bus_write(IO_CNTC, 32'h1);
        bus_read(IO_CNT, 32'd0, "cnt_after_clr");
        bus_read(IO_CNT, 32'd1, "cnt_next");
        repeat (2) tick();
        bus_read(IO_CNT, 32'd4, "cnt_plus3");

        force dut.cnt_q = 32'hFFFF_FFFF;
        exp_rd_q.push_back(32'hFFFF_FFFF);
        rd_name_q.push_back("cnt_max");
        bus.io_addr = IO_CNT;
        bus.io_rd   = 1'b1;
        @(negedge clk);
        #1;
        release dut.cnt_q;
        tick();
        bus.io_rd = 1'b0;
        bus_read(IO_CNT, 32'd0, "cnt_wrap");

        // FIFO overflow with consumer stalled
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_tx_q.push_back(fill1[i]);
            bus_write(IO_TXD, {24'h0, fill1[i]});
        end
        bus_read(IO_TXS, 32'h0000_0045, "txs_full_ovf");
        bus_read(IO_TXS, 32'h0000_0041, "txs_ovf_cleared");
        tx_ready = 1'b1;
        wait_tx_empty("tx_drained_1");

        // Push into a full FIFO with a same-cycle pop
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_tx_q.push_back(fill2[i]);
            bus_write(IO_TXD, {24'h0, fill2[i]});
        end
        tx_ready = 1'b1;
        exp_tx_q.push_back(8'h66);
        bus_write(IO_TXD, 32'h66);
        tx_ready = 1'b0;
        bus_read(IO_TXS, 32'h0000_0041, "txs_full_pop_push");
        tx_ready = 1'b1;
        wait_tx_empty("tx_drained_2");

        // Asynchronous reset in the middle of a drain
        tx_ready = 1'b0;
        exp_tx_q.push_back(8'h77);
        bus_write(IO_TXD, 32'h77);
        bus_write(IO_TXD, 32'h88);
        tx_ready = 1'b1;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data), 32'd0);
        check("rst_mid_led", 32'(led), 32'd0);
        tick();
        rstn     = 1'b1;
        tx_ready = 1'b0;
        bus_read(IO_TXS, 32'h0000_0002, "txs_after_rst");

        repeat (2) tick();
        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
        check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
